// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader: FSM states and the
// registered output bundle decoded from each state.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    LOADER_IDLE,
    LOADER_WAIT_BYTE,
    LOADER_DRIVE_ADDR,
    LOADER_DRIVE_DATA,
    LOADER_DONE,
    LOADER_ERROR
  } loader_state_e;

  typedef struct packed {
    logic in_ready;
    logic bus_oe;
    logic c_mi;
    logic c_ri;
    logic cpu_hold;
    logic done;
    logic error;
  } loader_out_t;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CNT_W  = 9;
  localparam logic [CNT_W-1:0] CNT_LAST_SLOT = 9'd255;

  function automatic loader_out_t decode_out(
    input loader_state_e s
  );
    loader_out_t o;
    o          = '0;
    o.cpu_hold = 1'b1;
    case (s)
      LOADER_WAIT_BYTE:  o.in_ready = 1'b1;
      LOADER_DRIVE_ADDR: begin
        o.bus_oe = 1'b1;
        o.c_mi   = 1'b1;
      end
      LOADER_DRIVE_DATA: begin
        o.bus_oe = 1'b1;
        o.c_ri   = 1'b1;
      end
      LOADER_DONE: begin
        o.done     = 1'b1;
        o.cpu_hold = 1'b0;
      end
      LOADER_ERROR:      o.error = 1'b1;
      default:           o.cpu_hold = 1'b1;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/prog_loader_addr_counter.sv
// RAM write address (wrapping) and bytes-written count for
// the program loader.
module prog_loader_addr_counter
  import prog_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] START_ADDR = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_last_slot
);

  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_addr  <= START_ADDR;
      r_count <= '0;
    end else if (i_inc) begin
      r_addr  <= r_addr + 1'b1;
      r_count <= r_count + 1'b1;
    end
  end

  assign o_addr      = r_addr;
  assign o_count     = r_count;
  // The byte now being written is the 256th one
  assign o_last_slot = (r_count == CNT_LAST_SLOT);

endmodule

// File: rtl/prog_loader.sv
// Bus-master loader: writes a handshaked byte stream into RAM
// via MAR/RAM strobes while holding the CPU in reset.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0] START_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       c_mi,
  output logic       c_ri,
  output logic       cpu_hold,
  output logic       done,
  output logic       error,
  output logic [8:0] count
);

  loader_state_e r_state;
  loader_state_e w_nxt;
  loader_out_t   r_out;
  logic [7:0]    r_bus;
  logic [7:0]    w_bus_nxt;
  logic [7:0]    r_byte;
  logic          r_last;
  logic [7:0]    w_addr;
  logic          w_last_slot;
  logic          w_idle_like;
  logic          w_accept;
  logic          w_clr;
  logic          w_inc;

  assign w_idle_like = (r_state == LOADER_IDLE)
                    || (r_state == LOADER_DONE)
                    || (r_state == LOADER_ERROR);
  assign w_accept = (r_state == LOADER_WAIT_BYTE) && in_valid;
  assign w_clr    = start && w_idle_like;
  assign w_inc    = (r_state == LOADER_DRIVE_DATA);

  prog_loader_addr_counter #(
    .START_ADDR(START_ADDR)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_clr),
    .i_inc      (w_inc),
    .o_addr     (w_addr),
    .o_count    (count),
    .o_last_slot(w_last_slot)
  );

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      LOADER_IDLE,
      LOADER_DONE,
      LOADER_ERROR: begin
        if (start) w_nxt = LOADER_WAIT_BYTE;
      end
      LOADER_WAIT_BYTE: begin
        if (w_accept) w_nxt = LOADER_DRIVE_ADDR;
      end
      LOADER_DRIVE_ADDR: w_nxt = LOADER_DRIVE_DATA;
      LOADER_DRIVE_DATA: begin
        if (r_last)           w_nxt = LOADER_DONE;
        else if (w_last_slot) w_nxt = LOADER_ERROR;
        else                  w_nxt = LOADER_WAIT_BYTE;
      end
      default: w_nxt = LOADER_IDLE;
    endcase
  end

  // Bus value is registered with the state so it is stable all cycle
  always_comb begin
    w_bus_nxt = '0;
    if (w_nxt == LOADER_DRIVE_ADDR) w_bus_nxt = w_addr;
    if (w_nxt == LOADER_DRIVE_DATA) w_bus_nxt = r_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOADER_IDLE;
      r_out   <= decode_out(LOADER_IDLE);
      r_bus   <= '0;
      r_byte  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_out   <= decode_out(w_nxt);
      r_bus   <= w_bus_nxt;
      if (w_accept) begin
        r_byte <= in_data;
        r_last <= in_last;
      end
    end
  end

  assign in_ready = r_out.in_ready;
  assign bus_oe   = r_out.bus_oe;
  assign c_mi     = r_out.c_mi;
  assign c_ri     = r_out.c_ri;
  assign cpu_hold = r_out.cpu_hold;
  assign done     = r_out.done;
  assign error    = r_out.error;
  assign bus_out  = r_bus;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected (addr,data)
// writes queued at send time, checked on the strobes.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready, bus_oe, c_mi, c_ri;
  logic       cpu_hold, done, error;
  logic [7:0] bus_out;
  logic [8:0] count;

  logic       start2 = 1'b0;
  logic [7:0] in_data2 = '0;
  logic       in_valid2 = 1'b0;
  logic       in_last2 = 1'b0;
  logic       in_ready2, bus_oe2, c_mi2, c_ri2;
  logic       cpu_hold2, done2, error2;
  logic [7:0] bus_out2;
  logic [8:0] count2;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready),
    .bus_out(bus_out), .bus_oe(bus_oe),
    .c_mi(c_mi), .c_ri(c_ri), .cpu_hold(cpu_hold),
    .done(done), .error(error), .count(count)
  );

  prog_loader #(.START_ADDR(8'h10)) dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .in_data(in_data2), .in_valid(in_valid2),
    .in_last(in_last2), .in_ready(in_ready2),
    .bus_out(bus_out2), .bus_oe(bus_oe2),
    .c_mi(c_mi2), .c_ri(c_ri2), .cpu_hold(cpu_hold2),
    .done(done2), .error(error2), .count(count2)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          t0 = 0;
  int          n_mi = 0;
  int          n_ri = 0;
  bit          mon_en = 0;
  logic [7:0]  exp_addr = '0;
  logic [15:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (c_mi) begin
        n_mi++;
        chk("mi_oe", bus_oe, 1);
        chk("excl", c_ri, 0);
        if (q.size() == 0) chk("mi_unexpected", 1, 0);
        else chk("addr", bus_out, q[0][15:8]);
      end
      if (c_ri) begin
        logic [15:0] e;
        n_ri++;
        chk("ri_oe", bus_oe, 1);
        if (q.size() == 0) chk("ri_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          chk("data", bus_out, e[7:0]);
        end
      end
      if (!bus_oe) chk("bus_idle", bus_out, 0);
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_load();
    @(negedge clk);
    n_mi = 0;
    n_ri = 0;
    q.delete();
    exp_addr = 8'h00;
    start = 1'b1;
    t0 = cyc;
  endtask

  task automatic send(input logic [7:0] b, input logic last,
                      input int stall);
    int w;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    q.push_back({exp_addr, b});
    exp_addr++;
    repeat (stall) begin
      chk("stall_ready", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    @(posedge clk);
  endtask

  task automatic wait_flag(input string tag, input bit want_err);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(want_err ? error : done) && w < 50);
    chk(tag, want_err ? error : done, 1);
  endtask

  task automatic send_abc(input int stall);
    send(8'hA0, 1'b0, stall);
    send(8'hB1, 1'b0, stall);
    send(8'hC2, 1'b1, stall);
    wait_flag("done_abc", 0);
    in_valid = 1'b0;
    chk("abc_count", count, 3);
    chk("abc_hold", cpu_hold, 0);
    chk("abc_mi", n_mi, 3);
    chk("abc_ri", n_ri, 3);
    chk("abc_q", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    apply_reset();
    mon_en = 1;
    chk("rst_ready", in_ready, 0);
    chk("rst_oe", bus_oe, 0);
    chk("rst_bus", bus_out, 0);
    chk("rst_mi", c_mi, 0);
    chk("rst_ri", c_ri, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_count", count, 0);

    // Full-rate stream; DONE lands 10 cycles after start
    start_load();
    send_abc(0);
    chk("done_latency", cyc - t0, 10);

    // Source stalls before every byte
    start_load();
    send_abc(4);

    // 256 bytes with no last -> overflow
    start_load();
    for (int i = 0; i < 256; i++) send(i[7:0], 1'b0, 0);
    wait_flag("ovf_error", 1);
    in_valid = 1'b0;
    chk("ovf_count", count, 256);
    chk("ovf_hold", cpu_hold, 1);
    chk("ovf_done", done, 0);
    chk("ovf_ri", n_ri, 256);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (5) begin
      chk("ovf_ready", in_ready, 0);
      @(negedge clk);
    end
    chk("ovf_no_strobe", n_mi, 256);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_err", error, 0);
    chk("restart_ready", in_ready, 1);
    chk("restart_count", count, 0);

    // Reset during DRIVE_ADDR of byte 2
    apply_reset();
    start_load();
    send(8'h11, 1'b0, 0);
    send(8'h22, 1'b0, 0);
    @(negedge clk);
    chk("mid_mi", c_mi, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_mi", c_mi, 0);
    chk("mrst_ri", c_ri, 0);
    chk("mrst_oe", bus_oe, 0);
    chk("mrst_hold", cpu_hold, 1);
    chk("mrst_count", count, 0);
    start_load();
    send(8'h55, 1'b1, 0);
    wait_flag("fresh_done", 0);
    in_valid = 1'b0;
    chk("fresh_count", count, 1);
    chk("fresh_q", q.size(), 0);

    // start pulse mid-load is ignored
    start_load();
    send(8'hA0, 1'b0, 0);
    @(negedge clk);
    start = 1'b1;
    send(8'hB1, 1'b0, 0);
    send(8'hC2, 1'b1, 0);
    wait_flag("ign_done", 0);
    in_valid = 1'b0;
    chk("ign_count", count, 3);
    chk("ign_mi", n_mi, 3);
    chk("ign_q", q.size(), 0);

    // Single byte at START_ADDR 0x10
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("d2_ready", in_ready2, 1);
    in_valid2 = 1'b1;
    in_data2  = 8'h3F;
    in_last2  = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    chk("d2_mi", c_mi2, 1);
    chk("d2_addr", bus_out2, 8'h10);
    @(negedge clk);
    chk("d2_ri", c_ri2, 1);
    chk("d2_data", bus_out2, 8'h3F);
    @(negedge clk);
    chk("d2_done", done2, 1);
    chk("d2_count", count2, 1);
    chk("d2_hold", cpu_hold2, 0);
    chk("d2_oe", bus_oe2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
